game_control: RTL and testbench
===============================

GAME_CONTROL -- requirements
Module: game_control

Interface
REQ-001 SHALL have parameter SCORE_DIV, default 6, giving frames per score increment in RUN.
REQ-002 SHALL have parameter DEAD_HOLD, default 30, giving frames in DEAD before a restart key is accepted.
REQ-003 SHALL have port clk, input, 1, system clock; all state updates on rising edge.
REQ-004 SHALL have port rstn, input, 1, reset, synchronous and active-low.
REQ-005 SHALL have port crash, input, 1, per-pixel collision flag from collision_detection; valid every cycle.
REQ-006 SHALL have port frame_tick, input, 1, one-cycle pulse at the start of each video frame.
REQ-007 SHALL have port key, input, 1, debounced jump/start button, level; active-high.
REQ-008 SHALL have port state, output, 2, game state: 0 IDLE, 1 RUN, 2 DEAD.
REQ-009 SHALL have port run_en, output, 1, high only in RUN; enables scrolling and obstacle motion.
REQ-010 SHALL have port game_over, output, 1, high only in DEAD.
REQ-011 SHALL have port score, output, 16, current score as 4 BCD digits, [15:12] thousands.
REQ-012 SHALL have port hi_score, output, 16, best score since reset, 4 BCD digits.
REQ-013 SHALL have port speed, output, 3, scroll speed level 0..7.
REQ-014 SHALL have port restart, output, 1, one-cycle pulse on every entry to RUN; clears dino/obstacle state downstream.

Function
REQ-015 SHALL detect key rising edge (key_prev registered; edge = key & ~key_prev), one cycle latency.
REQ-016 SHALL implement FSM IDLE, RUN, DEAD; state, run_en, game_over registered and mutually consistent.
REQ-017 IDLE: key edge -> RUN next cycle; restart pulses in that transition cycle's successor (same cycle state becomes RUN).
REQ-018 RUN: crash high in any cycle sets sticky crash_acc; at frame_tick, if crash_acc or crash is high that cycle -> DEAD, crash_acc cleared.
REQ-019 crash_acc SHALL be ignored and held clear in IDLE and DEAD.
REQ-020 RUN: frame counter counts frame_ticks 0..SCORE_DIV-1; on wrap score increments by 1 in BCD.
REQ-021 Score SHALL saturate at 9999; no wrap to 0000.
REQ-022 speed SHALL increment by 1 each time score increments to a multiple of 100 (tens and units both 0), saturating at 7.
REQ-023 A frame_tick that moves RUN -> DEAD SHALL NOT increment score.
REQ-024 On entry to DEAD, hi_score SHALL load score if score > hi_score (BCD compare == binary compare of digits MSB first), same cycle as state change.
REQ-025 DEAD: hold counter counts frame_ticks up to DEAD_HOLD, saturating; key edge ignored while counter < DEAD_HOLD.
REQ-026 DEAD with counter = DEAD_HOLD and key edge -> RUN; score, speed, frame counter cleared; restart pulses; hi_score kept.
REQ-027 key edge and frame_tick in same cycle: key edge processed per state rules; frame counters in new state start from 0.
REQ-028 key held high continuously SHALL produce only one transition.

Reset
REQ-029 rstn low at a clk edge SHALL force: state IDLE, run_en 0, game_over 0, restart 0, score 0000, hi_score 0000, speed 0, all counters and crash_acc 0, key_prev 0.
REQ-030 Reset mid-RUN or mid-DEAD SHALL take effect in one cycle with no restart pulse and no hi_score update.

Verification
REQ-031 Reset, then key rise -> state=1, run_en=1, restart one-cycle pulse; score=0000.
REQ-032 RUN, 60 frame_ticks, no crash, SCORE_DIV=6 -> score=0010, speed=0.
REQ-033 RUN, crash high 1 cycle mid-frame -> at next frame_tick state=2, game_over=1, run_en=0, hi_score=score.
REQ-034 DEAD, key edge after 10 frames -> ignored; after 30 frames key edge -> state=1, score=0000, speed=0, hi_score unchanged, restart pulse.
REQ-035 Force score to 0099 then one increment -> score=0100, speed=1; drive to 9999 with speed 7 -> further increments leave 9999 and 7.
REQ-036 rstn low for one cycle during DEAD with hi_score=0042 -> state=0, hi_score=0000, no restart pulse.

Source files
------------

// File: rtl/game_control.sv
// Game state controller: IDLE/RUN/DEAD sequencing, BCD score with saturation,
// best-score tracking, speed level and restart pulse generation.
module game_control #(
   parameter int SCORE_DIV = 6,
   parameter int DEAD_HOLD = 30
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        crash,
   input  logic        frame_tick,
   input  logic        key,
   output logic [1:0]  state,
   output logic        run_en,
   output logic        game_over,
   output logic [15:0] score,
   output logic [15:0] hi_score,
   output logic [2:0]  speed,
   output logic        restart
);

   localparam int FW = (SCORE_DIV > 1) ? $clog2(SCORE_DIV) : 1;
   localparam int HW = (DEAD_HOLD > 0) ? $clog2(DEAD_HOLD + 1) : 1;
   localparam logic [FW-1:0] FRAME_LAST = FW'(SCORE_DIV - 1);
   localparam logic [HW-1:0] HOLD_MAX   = HW'(DEAD_HOLD);
   localparam logic [15:0]   SCORE_MAX  = 16'h9999;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DEAD = 2'd2
   } state_e;

   state_e        state_q, state_d;
   logic          run_en_q, run_en_d;
   logic          game_over_q, game_over_d;
   logic          restart_q, restart_d;
   logic [15:0]   score_q, score_d;
   logic [15:0]   hi_score_q, hi_score_d;
   logic [2:0]    speed_q, speed_d;
   logic [FW-1:0] frame_q, frame_d;
   logic [HW-1:0] hold_q, hold_d;
   logic          crash_acc_q, crash_acc_d;
   logic          key_prev_q, key_prev_d;

   logic          key_edge;
   logic          crash_seen;
   logic [15:0]   score_inc;

   // Ripple-carry increment across the four BCD digits.
   function automatic logic [15:0] bcd_inc(input logic [15:0] v);
      logic [15:0] r;
      logic        c;
      r = v;
      c = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (c) begin
            if (r[i*4 +: 4] == 4'd9) begin
               r[i*4 +: 4] = 4'd0;
            end else begin
               r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
               c           = 1'b0;
            end
         end
      end
      return r;
   endfunction

   assign key_edge   = key & ~key_prev_q;
   assign crash_seen = crash_acc_q | crash;
   assign score_inc  = bcd_inc(score_q);

   always_comb begin
      state_d     = state_q;
      restart_d   = 1'b0;
      score_d     = score_q;
      hi_score_d  = hi_score_q;
      speed_d     = speed_q;
      frame_d     = frame_q;
      hold_d      = hold_q;
      crash_acc_d = 1'b0;
      key_prev_d  = key;

      case (state_q)
         S_IDLE: begin
            if (key_edge) begin
               state_d   = S_RUN;
               restart_d = 1'b1;
               score_d   = 16'h0000;
               speed_d   = 3'd0;
               frame_d   = '0;
            end
         end

         S_RUN: begin
            crash_acc_d = crash_seen;
            if (frame_tick) begin
               if (crash_seen) begin
                  // Dying tick never scores; best score latched on the way out.
                  state_d     = S_DEAD;
                  crash_acc_d = 1'b0;
                  hold_d      = '0;
                  if (score_q > hi_score_q) hi_score_d = score_q;
               end else if (frame_q == FRAME_LAST) begin
                  frame_d = '0;
                  if (score_q != SCORE_MAX) begin
                     score_d = score_inc;
                     if (score_inc[7:0] == 8'h00 && speed_q != 3'd7)
                        speed_d = speed_q + 3'd1;
                  end
               end else begin
                  frame_d = frame_q + FW'(1);
               end
            end
         end

         S_DEAD: begin
            if (key_edge && hold_q == HOLD_MAX) begin
               state_d   = S_RUN;
               restart_d = 1'b1;
               score_d   = 16'h0000;
               speed_d   = 3'd0;
               frame_d   = '0;
               hold_d    = '0;
            end else if (frame_tick && hold_q != HOLD_MAX) begin
               hold_d = hold_q + HW'(1);
            end
         end

         default: state_d = S_IDLE;
      endcase

      run_en_d    = (state_d == S_RUN);
      game_over_d = (state_d == S_DEAD);
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q     <= S_IDLE;
         run_en_q    <= 1'b0;
         game_over_q <= 1'b0;
         restart_q   <= 1'b0;
         score_q     <= 16'h0000;
         hi_score_q  <= 16'h0000;
         speed_q     <= 3'd0;
         frame_q     <= '0;
         hold_q      <= '0;
         crash_acc_q <= 1'b0;
         key_prev_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         run_en_q    <= run_en_d;
         game_over_q <= game_over_d;
         restart_q   <= restart_d;
         score_q     <= score_d;
         hi_score_q  <= hi_score_d;
         speed_q     <= speed_d;
         frame_q     <= frame_d;
         hold_q      <= hold_d;
         crash_acc_q <= crash_acc_d;
         key_prev_q  <= key_prev_d;
      end
   end

   assign state     = state_q;
   assign run_en    = run_en_q;
   assign game_over = game_over_q;
   assign restart   = restart_q;
   assign score     = score_q;
   assign hi_score  = hi_score_q;
   assign speed     = speed_q;

endmodule

// File: tb/tb_game_control.sv
// Bench for game_control: integer-score reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_game_control;

   localparam int SCORE_DIV = 6;
   localparam int DEAD_HOLD = 30;

   logic        clk = 1'b0;
   logic        rstn, crash, frame_tick, key;
   logic [1:0]  state;
   logic        run_en, game_over, restart;
   logic [15:0] score, hi_score;
   logic [2:0]  speed;

   int errors = 0;
   int checks = 0;

   game_control #(.SCORE_DIV(SCORE_DIV), .DEAD_HOLD(DEAD_HOLD)) dut (
      .clk(clk), .rstn(rstn), .crash(crash), .frame_tick(frame_tick), .key(key),
      .state(state), .run_en(run_en), .game_over(game_over), .score(score),
      .hi_score(hi_score), .speed(speed), .restart(restart)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: score kept as a plain integer, speed derived from it.
   typedef struct {
      int st;
      int sc;
      int hi;
      int fr;
      int hd;
      bit acc;
      bit kp;
      bit rs;
   } mdl_t;

   mdl_t m = '{0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0};

   function automatic mdl_t step(input mdl_t c, input bit rn, input bit k,
                                 input bit cr, input bit ft);
      mdl_t n;
      bit   edge_k;
      n = c;
      if (!rn) return '{0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0};
      edge_k = k && !c.kp;
      n.kp   = k;
      n.rs   = 1'b0;
      if (c.st == 0) begin
         n.acc = 1'b0;
         if (edge_k) begin
            n.st = 1; n.sc = 0; n.fr = 0; n.rs = 1'b1;
         end
      end else if (c.st == 1) begin
         n.acc = c.acc || cr;
         if (ft) begin
            if (n.acc) begin
               n.st = 2; n.acc = 1'b0; n.hd = 0;
               if (c.sc > c.hi) n.hi = c.sc;
            end else begin
               n.fr = c.fr + 1;
               if (n.fr == SCORE_DIV) begin
                  n.fr = 0;
                  n.sc = (c.sc + 1 > 9999) ? 9999 : c.sc + 1;
               end
            end
         end
      end else begin
         n.acc = 1'b0;
         if (edge_k && c.hd == DEAD_HOLD) begin
            n.st = 1; n.sc = 0; n.fr = 0; n.hd = 0; n.rs = 1'b1;
         end else if (ft && c.hd < DEAD_HOLD) begin
            n.hd = c.hd + 1;
         end
      end
      return n;
   endfunction

   function automatic logic [15:0] to_bcd(input int v);
      return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
   endfunction

   always @(posedge clk) m <= step(m, rstn, key, crash, frame_tick);

   int m_speed;
   always @(negedge clk) begin
      m_speed = (m.sc / 100 > 7) ? 7 : m.sc / 100;
      chk("state",     32'(state),     32'(m.st));
      chk("run_en",    32'(run_en),    32'(m.st == 1));
      chk("game_over", 32'(game_over), 32'(m.st == 2));
      chk("score",     32'(score),     32'(to_bcd(m.sc)));
      chk("hi_score",  32'(hi_score),  32'(to_bcd(m.hi)));
      chk("speed",     32'(speed),     32'(m_speed));
      chk("restart",   32'(restart),   32'(m.rs));
   end

   // Drive one cycle of inputs, then land 2 time units after the edge.
   task automatic cyc(input logic ft, input logic k, input logic cr);
      frame_tick = ft;
      key        = k;
      crash      = cr;
      @(posedge clk);
      #2;
   endtask

   task automatic frames(input int n, input int gap, input logic k);
      for (int i = 0; i < n; i++) begin
         cyc(1'b1, k, 1'b0);
         for (int j = 0; j < gap; j++) cyc(1'b0, k, 1'b0);
      end
   endtask

   initial begin
      rstn = 1'b0; crash = 1'b0; frame_tick = 1'b0; key = 1'b0;
      repeat (3) cyc(1'b0, 1'b0, 1'b0);
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_score", 32'(score), 32'h0000);
      chk("rst_hi",    32'(hi_score), 32'h0000);
      chk("rst_speed", 32'(speed), 32'd0);
      chk("rst_restart", 32'(restart), 32'd0);

      rstn = 1'b1;
      cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b0);
      chk("start_state",   32'(state),   32'd1);
      chk("start_run_en",  32'(run_en),  32'd1);
      chk("start_restart", 32'(restart), 32'd1);
      chk("start_score",   32'(score),   32'h0000);
      cyc(1'b0, 1'b1, 1'b0);
      chk("restart_one_cycle", 32'(restart), 32'd0);

      frames(60, 3, 1'b1);
      chk("score_60f", 32'(score), 32'h0010);
      chk("speed_60f", 32'(speed), 32'd0);

      cyc(1'b0, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
      chk("crash_pending", 32'(state), 32'd1);
      cyc(1'b1, 1'b0, 1'b0);
      chk("dead_state",  32'(state),     32'd2);
      chk("dead_go",     32'(game_over), 32'd1);
      chk("dead_run_en", 32'(run_en),    32'd0);
      chk("dead_hi",     32'(hi_score),  32'h0010);
      chk("dead_score",  32'(score),     32'h0010);

      frames(10, 1, 1'b0);
      cyc(1'b0, 1'b1, 1'b0);
      chk("early_key_ignored", 32'(state), 32'd2);
      cyc(1'b0, 1'b0, 1'b0);
      frames(20, 1, 1'b0);
      cyc(1'b0, 1'b1, 1'b0);
      chk("rerun_state",   32'(state),    32'd1);
      chk("rerun_score",   32'(score),    32'h0000);
      chk("rerun_speed",   32'(speed),    32'd0);
      chk("rerun_hi",      32'(hi_score), 32'h0010);
      chk("rerun_restart", 32'(restart),  32'd1);
      cyc(1'b0, 1'b0, 1'b0);

      frames(252, 0, 1'b0);
      chk("score_42", 32'(score), 32'h0042);
      cyc(1'b1, 1'b0, 1'b1);
      chk("dead2_state", 32'(state),    32'd2);
      chk("dead2_hi",    32'(hi_score), 32'h0042);
      chk("dead2_score", 32'(score),    32'h0042);

      cyc(1'b0, 1'b0, 1'b0);
      rstn = 1'b0;
      cyc(1'b0, 1'b0, 1'b0);
      chk("midrst_state",   32'(state),    32'd0);
      chk("midrst_hi",      32'(hi_score), 32'h0000);
      chk("midrst_restart", 32'(restart),  32'd0);
      rstn = 1'b1;
      cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b0);
      chk("start3_state", 32'(state), 32'd1);
      cyc(1'b0, 1'b0, 1'b0);

      frames(594, 0, 1'b0);
      chk("score_0099", 32'(score), 32'h0099);
      chk("speed_0099", 32'(speed), 32'd0);
      frames(6, 0, 1'b0);
      chk("score_0100", 32'(score), 32'h0100);
      chk("speed_0100", 32'(speed), 32'd1);
      frames(9899 * 6, 0, 1'b0);
      chk("score_9999", 32'(score), 32'h9999);
      chk("speed_9999", 32'(speed), 32'd7);
      frames(12, 0, 1'b0);
      chk("score_sat", 32'(score), 32'h9999);
      chk("speed_sat", 32'(speed), 32'd7);
      cyc(1'b0, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
